pattern_sequencer: RTL

Playback controller and write arbiter for the eight-buffer pattern store. It steps through a configured range of buffers and fields and drives the buffer-select, buffer-pointer and one-hot field-pointer inputs of the buffer array. It also shares the single `bufp` pointer between playback reads and single-byte field writes. It sits between the top-level control registers and the buffer array.

---
 rtl/pattern_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - playback stepper and write arbiter for the eight-buffer pattern store
module pattern_sequencer #(
    parameter int buffer_size  = 22,
    parameter int buffer_width = 8,
    parameter int no_bufs      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    step,
    input  logic                    loop_en,
    input  logic [2:0]              first_buf,
    input  logic [2:0]              last_buf,
    input  logic [4:0]              field_len,
    input  logic                    wr_req,
    input  logic [2:0]              wr_buf,
    input  logic [4:0]              wr_field,
    input  logic [buffer_width-1:0] wr_data,
    output logic                    wr_ack,
    output logic                    wr_err,
    output logic [no_bufs-1:0]      buffer_select,
    output logic [2:0]              bufp,
    output logic [buffer_size-1:0]  fieldp,
    output logic [buffer_size-1:0]  fieldwp,
    output logic [buffer_width-1:0] field_in,
    output logic                    field_write,
    output logic                    field_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    wrap
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] max_len = 5'(buffer_size);

    state_t     state, state_next;
    logic [2:0] cfg_first, cfg_last, cur_buf;
    logic [2:0] first_next, last_next, cur_buf_next, bufp_next;
    logic [4:0] cfg_len, len_next, field, field_next, len_eff;
    logic       cfg_loop, loop_next, done_next, wrap_next;
    logic       wr_accept, wr_field_ok;

    assign len_eff     = (field_len == 5'd0 || field_len > max_len) ? max_len : field_len;
    // Playback owns bufp on a step cycle unless the write targets the same buffer
    assign wr_ack      = wr_req && !(state == RUN && step && wr_buf != cur_buf);
    assign wr_accept   = wr_req && wr_ack;
    assign wr_field_ok = wr_field < max_len;

    always_comb begin
        state_next   = state;
        first_next   = cfg_first;
        last_next    = cfg_last;
        len_next     = cfg_len;
        loop_next    = cfg_loop;
        cur_buf_next = cur_buf;
        field_next   = field;
        done_next    = 1'b0;
        wrap_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    first_next   = first_buf;
                    last_next    = last_buf;
                    len_next     = len_eff;
                    loop_next    = loop_en;
                    cur_buf_next = first_buf;
                    field_next   = 5'd0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (step) begin
                    if (field < cfg_len - 5'd1) begin
                        field_next = field + 5'd1;
                    end else begin
                        field_next = 5'd0;
                        if (cur_buf != cfg_last) begin
                            cur_buf_next = cur_buf + 3'd1;
                        end else if (cfg_loop) begin
                            cur_buf_next = cfg_first;
                            wrap_next    = 1'b1;
                        end else begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        bufp_next = (wr_accept && wr_field_ok) ? wr_buf : cur_buf_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_first     <= 3'd0;
            cfg_last      <= 3'd0;
            cfg_len       <= max_len;
            cfg_loop      <= 1'b0;
            cur_buf       <= 3'd0;
            field         <= 5'd0;
            buffer_select <= no_bufs'(1);
            bufp          <= 3'd0;
            fieldp        <= buffer_size'(1);
            fieldwp       <= buffer_size'(1);
            field_in      <= '0;
            field_write   <= 1'b0;
            field_valid   <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            wrap          <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            state         <= state_next;
            cfg_first     <= first_next;
            cfg_last      <= last_next;
            cfg_len       <= len_next;
            cfg_loop      <= loop_next;
            cur_buf       <= cur_buf_next;
            field         <= field_next;
            buffer_select <= no_bufs'(1) << cur_buf_next;
            bufp          <= bufp_next;
            fieldp        <= buffer_size'(1) << field_next;
            field_valid   <= (bufp_next == cur_buf_next);
            busy          <= (state_next == RUN);
            done          <= done_next;
            wrap          <= wrap_next;
            field_write   <= wr_accept && wr_field_ok;
            wr_err        <= wr_accept && !wr_field_ok;
            if (wr_accept && wr_field_ok) begin
                fieldwp  <= buffer_size'(1) << wr_field;
                field_in <= wr_data;
            end
        end
    end
endmodule
